// File: rtl/simon_key_expander.sv
// -----------------------------------------------------------------------------
// simon_key_expander
//
// Sequential key-expansion controller for the Simon 96/96 block cipher
// (word width N=48, M=2 key words). A start request latches the 96-bit master
// key and then produces one round key per clock into an NR-entry register
// store. The round datapath reads that store through a registered read port.
//
// Ports
//   clk        in   1      clock, rising edge
//   rst        in   1      asynchronous reset, active-high
//   start      in   1      request an expansion
//   key        in   2*N    master key; key[N-1:0] = k0, key[2N-1:N] = k1
//   busy       out  1      expansion in progress
//   done       out  1      one-cycle pulse after the last round key is written
//   keys_valid out  1      store holds the keys of the last completed expansion
//   rk_addr    in   AW     read index
//   rk_data    out  N      store[rk_addr], one cycle of latency; 0 if >= NR
//
// Build option
//   SIMON_KS_RESTART_EN  when defined, start while busy aborts the running
//                        expansion and reloads from the new key (no done pulse
//                        for the aborted run). When undefined, start is
//                        ignored while busy.
// -----------------------------------------------------------------------------
module simon_key_expander #(
  parameter int N  = 48,
  parameter int M  = 2,
  parameter int NR = 52,
  parameter int AW = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*N-1:0] key,
  output logic           busy,
  output logic           done,
  output logic           keys_valid,
  input  logic [AW-1:0]  rk_addr,
  output logic [N-1:0]   rk_data
);

  // Elaboration-time guards: only the two-word key schedule is implemented,
  // and the read address must be able to reach every stored entry.
  if (M != 2) begin : g_bad_m
    $error("simon_key_expander: only M=2 is supported");
  end
  if ((2 ** AW) < NR) begin : g_bad_aw
    $error("simon_key_expander: 2**AW must be >= NR");
  end

  // z2 sequence; character j from the left is bit (61 - j) of this literal.
  localparam logic [61:0] Z2 =
    62'b10101111011100000011010010011000101000010001111110010110110011;

  localparam logic [AW-1:0] LAST_IDX = AW'(NR - 1);

  typedef enum logic {
    IDLE,
    EXPAND
  } state_t;

  state_t state, next_state;

  logic [AW-1:0] idx;     // index of the round key written at the next edge
  logic [5:0]    zj;      // position in z2, (idx - 2) mod 62
  logic [N-1:0]  w_prev2; // k[idx-2]
  logic [N-1:0]  w_prev1; // k[idx-1]
  logic [N-1:0]  k_next;

  logic load;    // accept start: latch the master key
  logic step;    // write one round key
  logic finish;  // this step writes the final entry
  logic restart;

  logic [N-1:0] store [NR];

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of block ordering.
      state <= next_state;
    end
  end

`ifdef SIMON_KS_RESTART_EN
  assign restart = start;
`else
  assign restart = 1'b0;
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first; a missing branch
    // would otherwise hold its old value and infer a latch.
    next_state = state;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          next_state = EXPAND;
        end
      end
      EXPAND: begin
        if (restart) begin
          // Abort and reload; staying in EXPAND keeps busy high.
          load = 1'b1;
        end else begin
          step = 1'b1;
          if (idx == LAST_IDX) begin
            finish     = 1'b1;
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign busy = (state == EXPAND);

  // ---------------------------------------------------------------------------
  // Round function: k[i] = ~k[i-2] ^ u ^ z2[j] ^ 3, u = t ^ rotr(t,1),
  // t = rotr(k[i-1], 3). Operands come from the working registers, never from
  // the store, so the read port stays free for the round datapath.
  // ---------------------------------------------------------------------------
  logic [N-1:0] rot_t;
  logic [N-1:0] rot_u;
  logic         z_bit;

  always_comb begin
    rot_t  = {w_prev1[2:0], w_prev1[N-1:3]};
    rot_u  = rot_t ^ {rot_t[0], rot_t[N-1:1]};
    z_bit  = Z2[6'd61 - zj];
    k_next = ~w_prev2 ^ rot_u ^ {{(N-1){1'b0}}, z_bit} ^ N'(3);
  end

  // ---------------------------------------------------------------------------
  // Counters, working registers and handshake flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx        <= '0;
      zj         <= '0;
      w_prev2    <= '0;
      w_prev1    <= '0;
      done       <= 1'b0;
      keys_valid <= 1'b0;
    end else begin
      done <= finish;
      if (load) begin
        keys_valid <= 1'b0;
      end else if (finish) begin
        keys_valid <= 1'b1;
      end

      if (load) begin
        w_prev2 <= key[N-1:0];
        w_prev1 <= key[2*N-1:N];
        idx     <= AW'(2);
        zj      <= '0;
      end else if (step) begin
        w_prev2 <= w_prev1;
        w_prev1 <= k_next;
        idx     <= idx + AW'(1);
        zj      <= (zj == 6'd61) ? 6'd0 : zj + 6'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Round-key store
  // ---------------------------------------------------------------------------
  // NOTE: the store has no reset; its contents are only trusted once
  // keys_valid is set, and leaving it unreset lets it map onto plain
  // flops or RAM without a clear path.
  always_ff @(posedge clk) begin
    if (load) begin
      store[0] <= key[N-1:0];
      store[1] <= key[2*N-1:N];
    end else if (step) begin
      store[idx] <= k_next;
    end
  end

  // Registered read port; a same-edge write is seen one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rk_data <= '0;
    end else if (int'(rk_addr) < NR) begin
      rk_data <= store[rk_addr];
    end else begin
      rk_data <= '0;
    end
  end

endmodule

// File: tb/tb_simon_key_expander.sv
// -----------------------------------------------------------------------------
// tb_simon_key_expander
//
// Scoreboard bench for simon_key_expander. A reference model computes round
// keys directly from the Simon 96/96 key-schedule definition and tracks which
// store entries have been filled; each cycle it pushes the expected outputs
// into a queue that a separate monitor pops and compares.
// -----------------------------------------------------------------------------
module tb_simon_key_expander;

  localparam int N  = 48;
  localparam int NR = 52;
  localparam int AW = 6;

`ifdef SIMON_KS_RESTART_EN
  localparam bit RESTART = 1'b1;
`else
  localparam bit RESTART = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [2*N-1:0] key;
  logic          busy;
  logic          done;
  logic          keys_valid;
  logic [AW-1:0] rk_addr;
  logic [N-1:0]  rk_data;

  simon_key_expander #(.N(N), .M(2), .NR(NR), .AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .key        (key),
    .busy       (busy),
    .done       (done),
    .keys_valid (keys_valid),
    .rk_addr    (rk_addr),
    .rk_data    (rk_data)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Reference key schedule, straight from the cipher definition
  // ---------------------------------------------------------------------------
  string z2s = "10101111011100000011010010011000101000010001111110010110110011";

  function automatic logic [N-1:0] rotr(input logic [N-1:0] x, input int r);
    return (x >> r) | (x << (N - r));
  endfunction

  function automatic logic [N-1:0] ref_key(input logic [2*N-1:0] k, input int idx);
    logic [N-1:0] a, b, c, t;
    a = k[N-1:0];
    b = k[2*N-1:N];
    if (idx == 0) return a;
    for (int i = 2; i <= idx; i++) begin
      t = rotr(b, 3);
      t = t ^ rotr(t, 1);
      c = ~a ^ t ^ 48'd3;
      if (z2s[(i - 2) % 62] == "1") c = c ^ 48'd1;
      a = b;
      b = c;
    end
    return b;
  endfunction

  // ---------------------------------------------------------------------------
  // Model: store contents plus expansion progress, advanced once per edge
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [N-1:0] rk;
    bit           rk_known;
    bit           busy;
    bit           done;
    bit           kv;
  } exp_t;

  exp_t exp_q[$];

  logic [N-1:0]   mstore   [NR];
  bit             mwritten [NR];
  logic [2*N-1:0] mkey;
  bit             mbusy = 0, mdone = 0, mkv = 0;
  int             mnext = 0;

  always @(posedge clk) begin
    exp_t e;
    bit   acc;
    if (rst) begin
      mbusy = 0; mdone = 0; mkv = 0; mnext = 0;
    end else begin
      e.rk_known = (rk_addr >= NR) || mwritten[rk_addr];
      e.rk       = (rk_addr >= NR) ? '0 : mstore[rk_addr];
      acc   = start && (!mbusy || RESTART);
      mdone = 0;
      if (acc) begin
        mkey        = key;
        mstore[0]   = ref_key(key, 0);
        mstore[1]   = ref_key(key, 1);
        mwritten[0] = 1;
        mwritten[1] = 1;
        mnext = 2;
        mbusy = 1;
        mkv   = 0;
      end else if (mbusy) begin
        mstore[mnext]   = ref_key(mkey, mnext);
        mwritten[mnext] = 1;
        if (mnext == NR - 1) begin
          mbusy = 0;
          mdone = 1;
          mkv   = 1;
        end
        mnext++;
      end
      e.busy = mbusy;
      e.done = mdone;
      e.kv   = mkv;
      exp_q.push_back(e);
    end
  end

  // Monitor: compares the DUT against the oldest expectation each cycle.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.rk_known) check("sb_rk_data", 64'(rk_data), 64'(e.rk));
      check("sb_busy", 64'(busy), 64'(e.busy));
      check("sb_done", 64'(done), 64'(e.done));
      check("sb_keys_valid", 64'(keys_valid), 64'(e.kv));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  function automatic logic [2*N-1:0] rand_key();
    return {$urandom, $urandom, $urandom};
  endfunction

  // One-cycle start pulse; key is scrambled afterwards to show it is sampled
  // only at the accepting edge. Returns at the negedge after that edge.
  task automatic start_run(input logic [2*N-1:0] k);
    @(negedge clk);
    key   = k;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    key   = rand_key();
  endtask

  // Counts edges until done is seen; optionally randomises the read address.
  task automatic wait_done(output int cycles, input bit rand_addr);
    cycles = 0;
    while (cycles < 200) begin
      @(posedge clk);
      #2;
      cycles++;
      if (rand_addr) rk_addr = AW'($urandom_range(0, 63));
      if (done) return;
    end
    check("done_timeout", 64'(0), 64'(1));
  endtask

  task automatic sweep();
    for (int a = 0; a < 64; a++) begin
      @(negedge clk);
      rk_addr = AW'(a);
    end
    @(negedge clk);
  endtask

  task automatic read_check(input string name, input int a, input logic [N-1:0] exp);
    @(negedge clk);
    rk_addr = AW'(a);
    @(posedge clk);
    #2;
    check(name, 64'(rk_data), 64'(exp));
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  localparam logic [2*N-1:0] VEC_KEY = 96'h0d0c0b0a0908_050403020100;

  initial begin
    int             cyc;
    int             done_cnt;
    logic [2*N-1:0] ka, kb;

    rst = 1'b1; start = 1'b0; key = '0; rk_addr = '0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    check("reset_keys_valid", 64'(keys_valid), 64'(0));
    check("reset_rk_data", 64'(rk_data), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    // All-zero key: busy length, single done, first three keys.
    start_run('0);
    wait_done(cyc, 1'b0);
    check("zero_busy_cycles", 64'(cyc), 64'(50));
    @(posedge clk);
    #2;
    check("zero_done_single", 64'(done), 64'(0));
    check("zero_keys_valid", 64'(keys_valid), 64'(1));
    read_check("zero_k0", 0, 48'h0);
    read_check("zero_k1", 1, 48'h0);
    read_check("zero_k2", 2, 48'hFFFF_FFFF_FFFD);

    // Reference key: full store compared by the scoreboard; out-of-range reads.
    start_run(VEC_KEY);
    wait_done(cyc, 1'b1);
    sweep();
    read_check("addr52_zero", 52, 48'h0);
    read_check("addr63_zero", 63, 48'h0);
    read_check("vec_k51", 51, ref_key(VEC_KEY, 51));

    // Read of entry 10 across the edge that overwrites it.
    ka = rand_key();
    @(negedge clk);
    key = ka; start = 1'b1; rk_addr = AW'(10);
    @(posedge clk);
    #2;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    check("rdw_k10_old", 64'(rk_data), 64'(ref_key(VEC_KEY, 10)));
    @(posedge clk);
    #2;
    check("rdw_k10_new", 64'(rk_data), 64'(ref_key(ka, 10)));
    wait_done(cyc, 1'b1);

    // Second start 20 cycles into a run.
    ka = rand_key();
    kb = rand_key();
    start_run(ka);
    repeat (19) @(negedge clk);
    key = kb; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc, 1'b1);
    check("midrun_start_latency", 64'(cyc), RESTART ? 64'(50) : 64'(30));
    done_cnt = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk);
      #2;
      if (done) done_cnt++;
    end
    check("midrun_extra_done", 64'(done_cnt), 64'(0));
    read_check("midrun_k51", 51, ref_key(RESTART ? kb : ka, 51));
    sweep();

    // Back-to-back: start in the done cycle.
    ka = rand_key();
    kb = rand_key();
    start_run(ka);
    wait_done(cyc, 1'b1);
    key = kb; start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    check("b2b_keys_valid_drop", 64'(keys_valid), 64'(0));
    check("b2b_busy", 64'(busy), 64'(1));
    wait_done(cyc, 1'b1);
    check("b2b_busy_cycles", 64'(cyc), 64'(50));
    sweep();

    // Asynchronous reset mid-run.
    start_run(rand_key());
    repeat (10) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_busy", 64'(busy), 64'(0));
    check("async_rst_done", 64'(done), 64'(0));
    check("async_rst_keys_valid", 64'(keys_valid), 64'(0));
    check("async_rst_rk_data", 64'(rk_data), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("post_rst_keys_valid", 64'(keys_valid), 64'(0));

    // A few random runs with random reads throughout.
    for (int r = 0; r < 3; r++) begin
      start_run(rand_key());
      wait_done(cyc, 1'b1);
      check("rand_busy_cycles", 64'(cyc), 64'(50));
      sweep();
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
